pool2x2_core: RTL and testbench

Streaming 2x2/stride-2 max-pooling stage with optional ReLU, placed directly downstream of the convolution core. It consumes the finished fp32 output-pixel stream (`pxl_ena_z`/`pxl_z`, raster order, one output row after another) and emits one pooled fp32 pixel per 2x2 window, also in raster order. Row-pair state is kept in a single half-width line buffer, so the block never stalls the convolution core.

---
 rtl/pool2x2_core.sv | 96 +++++++++
 tb/tb_pool2x2_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_core.sv
// pool2x2_core: streaming 2x2 stride-2 fp32 max-pool with optional ReLU.
// One half-width line buffer holds the even-row horizontal maxima.
module pool2x2_core #(
  parameter int C_WIDTH = 9,
  parameter int DEPTH   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               param_ena,
  input  logic [C_WIDTH-1:0] param_width_in,
  input  logic [C_WIDTH-1:0] param_height_in,
  input  logic               param_relu,
  input  logic               pxl_ena_z,
  input  logic [31:0]        pxl_z,
  output logic               pool_ena,
  output logic [31:0]        pool_data,
  output logic               pool_ovr
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  // Total order on fp32 bit patterns: negatives flipped, positives lifted above them
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka, kb;
    ka = a[31] ? ~a : a | 32'h8000_0000;
    kb = b[31] ? ~b : b | 32'h8000_0000;
    return kb > ka ? b : a;
  endfunction
  logic [C_WIDTH-1:0] w_q, h_q, col_q, row_q, col_d, row_d;
  logic               relu_q, s1_vld_q, s1_rd_q, s1_wr_q, s1_last_q, ena_q, ovr_q;
  logic [31:0]        held_q, s1_val_q, data_q, v, hmax, lb_rd;
  logic [AW-1:0]      s1_addr_q;
  logic [31:0]        lb_q [DEPTH];
  logic               beat, last_col, last_row;
  always_comb begin
    beat     = pxl_ena_z && !param_ena;
    v        = relu_q && pxl_z[31] ? 32'h0 : pxl_z;
    last_col = col_q == w_q - C_WIDTH'(1);
    last_row = row_q == h_q - C_WIDTH'(1);
    col_d    = last_col ? '0 : col_q + C_WIDTH'(1);
    row_d    = !last_col ? row_q : last_row ? '0 : row_q + C_WIDTH'(1);
    hmax     = fmax(held_q, v);
    lb_rd    = lb_q[s1_addr_q];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q       <= '0;
      h_q       <= '0;
      relu_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      held_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_rd_q   <= 1'b0;
      s1_wr_q   <= 1'b0;
      s1_last_q <= 1'b0;
      s1_val_q  <= '0;
      s1_addr_q <= '0;
      ena_q     <= 1'b0;
      data_q    <= '0;
      ovr_q     <= 1'b0;
    end else if (param_ena) begin
      w_q       <= param_width_in;
      h_q       <= param_height_in;
      relu_q    <= param_relu;
      col_q     <= '0;
      row_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      ena_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (beat) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (beat && !col_q[0]) held_q <= v;
      s1_vld_q  <= beat && col_q[0];
      s1_last_q <= beat && last_col && last_row;
      // A trailing even row of an odd-height frame is never paired, so it must not write
      if (beat && col_q[0]) begin
        s1_val_q  <= hmax;
        s1_addr_q <= col_q[AW:1];
        s1_rd_q   <= row_q[0];
        s1_wr_q   <= !row_q[0] && !last_row;
      end
      ena_q <= s1_vld_q && s1_rd_q;
      if (s1_vld_q && s1_rd_q) data_q <= fmax(lb_rd, s1_val_q);
      ovr_q <= s1_last_q;
    end
  end
  always_ff @(posedge clk) begin
    if (s1_vld_q && s1_wr_q) lb_q[s1_addr_q] <= s1_val_q;
  end
  assign pool_ena  = ena_q;
  assign pool_data = data_q;
  assign pool_ovr  = ovr_q;
endmodule

// File: tb/tb_pool2x2_core.sv
// tb_pool2x2_core: directed scenarios for the 2x2 max-pool stage.
module tb_pool2x2_core;
  logic        clk = 1'b0, rst = 1'b1, param_ena = 1'b0, param_relu = 1'b0, pxl_ena_z = 1'b0;
  logic [8:0]  param_width_in = '0, param_height_in = '0;
  logic [31:0] pxl_z = '0, pool_data;
  logic        pool_ena, pool_ovr;
  int          total = 0, bad = 0, cyc = 0;
  logic [31:0] oq[$], fr[$], exp_d[$];
  int          oc[$], ovc[$], exp_c[$], exp_o[$];
  logic [31:0] ftab [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  pool2x2_core #(.C_WIDTH(9), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .param_ena(param_ena), .param_width_in(param_width_in),
    .param_height_in(param_height_in), .param_relu(param_relu), .pxl_ena_z(pxl_ena_z),
    .pxl_z(pxl_z), .pool_ena(pool_ena), .pool_data(pool_data), .pool_ovr(pool_ovr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (pool_ena) begin
      oq.push_back(pool_data);
      oc.push_back(cyc);
    end
    if (pool_ovr) ovc.push_back(cyc);
  end

  task automatic clr;
    oq.delete(); oc.delete(); ovc.delete(); exp_d.delete(); exp_c.delete(); exp_o.delete();
  endtask

  task automatic load(input int w, input int h, input logic r);
    repeat (3) @(negedge clk);
    param_ena = 1'b1; param_width_in = 9'(w); param_height_in = 9'(h); param_relu = r;
    @(negedge clk);
    param_ena = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, output int bc);
    pxl_ena_z = 1'b1; pxl_z = d; bc = cyc;
    @(negedge clk);
    pxl_ena_z = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int maxg);
    int bc;
    bc = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        repeat ($urandom_range(0, maxg)) @(negedge clk);
        send(fr[r*w+c], bc);
        if (r % 2 == 1 && c % 2 == 1) exp_c.push_back(bc);
      end
    exp_o.push_back(bc);
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    total++; if (pool_ena !== 1'b0) begin bad++; $display("FAIL reset pool_ena got %b want 0", pool_ena); end
    total++; if (pool_data !== 32'h0) begin bad++; $display("FAIL reset pool_data got %h want 0", pool_data); end
    total++; if (pool_ovr !== 1'b0) begin bad++; $display("FAIL reset pool_ovr got %b want 0", pool_ovr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_4x4;
    clr();
    load(4, 4, 1'b0);
    fr.delete(); for (int i = 0; i < 16; i++) fr.push_back(ftab[i]);
    exp_d = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    send_frame(4, 4, 0);
    repeat (4) @(negedge clk);
    total++; if (oq.size() !== 4) begin bad++; $display("FAIL 4x4 count got %0d want 4", oq.size()); end
    foreach (exp_d[i]) if (i < oq.size()) begin
      total++; if (oq[i] !== exp_d[i]) begin bad++; $display("FAIL 4x4 data[%0d] got %h want %h", i, oq[i], exp_d[i]); end
      total++; if (oc[i] !== exp_c[i] + 2) begin bad++; $display("FAIL 4x4 latency[%0d] got %0d want %0d", i, oc[i], exp_c[i] + 2); end
    end
    total++; if (ovc.size() !== 1 || ovc[0] !== exp_o[0] + 2 || ovc[0] !== oc[3]) begin bad++; $display("FAIL 4x4 ovr n=%0d got %0d want %0d", ovc.size(), ovc[0], exp_o[0] + 2); end
  endtask

  task automatic test_negatives;
    clr();
    load(2, 2, 1'b0);
    fr = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000};
    send_frame(2, 2, 0);
    load(2, 2, 1'b1);
    send_frame(2, 2, 0);
    load(2, 2, 1'b0);
    fr = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000};
    send_frame(2, 2, 0);
    exp_d = '{32'hBF800000, 32'h00000000, 32'h00000000};
    repeat (4) @(negedge clk);
    total++; if (oq.size() !== 3) begin bad++; $display("FAIL neg count got %0d want 3", oq.size()); end
    foreach (exp_d[i]) if (i < oq.size()) begin
      total++; if (oq[i] !== exp_d[i]) begin bad++; $display("FAIL neg data[%0d] got %h want %h", i, oq[i], exp_d[i]); end
      total++; if (oc[i] !== exp_c[i] + 2) begin bad++; $display("FAIL neg latency[%0d] got %0d want %0d", i, oc[i], exp_c[i] + 2); end
    end
    total++; if (ovc.size() !== 3) begin bad++; $display("FAIL neg ovr count got %0d want 3", ovc.size()); end
  endtask

  task automatic test_odd_dims;
    clr();
    load(5, 3, 1'b0);
    fr.delete(); for (int i = 0; i < 15; i++) fr.push_back(ftab[i]);
    exp_d = '{32'h40E00000, 32'h41100000};
    send_frame(5, 3, 3);
    repeat (4) @(negedge clk);
    total++; if (oq.size() !== 2) begin bad++; $display("FAIL odd count got %0d want 2", oq.size()); end
    foreach (exp_d[i]) if (i < oq.size()) begin
      total++; if (oq[i] !== exp_d[i]) begin bad++; $display("FAIL odd data[%0d] got %h want %h", i, oq[i], exp_d[i]); end
      total++; if (oc[i] !== exp_c[i] + 2) begin bad++; $display("FAIL odd latency[%0d] got %0d want %0d", i, oc[i], exp_c[i] + 2); end
    end
    total++; if (ovc.size() !== 1 || ovc[0] !== exp_o[0] + 2) begin bad++; $display("FAIL odd ovr n=%0d got %0d want %0d", ovc.size(), ovc[0], exp_o[0] + 2); end
  endtask

  task automatic test_abort;
    int bc;
    clr();
    load(4, 4, 1'b0);
    repeat (6) send(32'h42C80000, bc);
    param_ena = 1'b1; pxl_ena_z = 1'b1; pxl_z = 32'h42C80000;
    @(negedge clk);
    param_ena = 1'b0; pxl_ena_z = 1'b0;
    fr.delete(); for (int i = 0; i < 16; i++) fr.push_back(ftab[i]);
    exp_d = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    send_frame(4, 4, 1);
    repeat (4) @(negedge clk);
    total++; if (oq.size() !== 4) begin bad++; $display("FAIL abort count got %0d want 4", oq.size()); end
    foreach (exp_d[i]) if (i < oq.size()) begin
      total++; if (oq[i] !== exp_d[i]) begin bad++; $display("FAIL abort data[%0d] got %h want %h", i, oq[i], exp_d[i]); end
      total++; if (oc[i] !== exp_c[i] + 2) begin bad++; $display("FAIL abort latency[%0d] got %0d want %0d", i, oc[i], exp_c[i] + 2); end
    end
    total++; if (ovc.size() !== 1 || ovc[0] !== exp_o[0] + 2) begin bad++; $display("FAIL abort ovr n=%0d got %0d want %0d", ovc.size(), ovc[0], exp_o[0] + 2); end
  endtask

  task automatic test_reset_mid;
    int bc;
    clr();
    load(2, 2, 1'b0);
    send(ftab[0], bc); send(ftab[1], bc); send(ftab[2], bc); send(ftab[4], bc);
    rst = 1'b0;
    #1;
    total++; if (pool_ena !== 1'b0) begin bad++; $display("FAIL rstmid pool_ena got %b want 0", pool_ena); end
    total++; if (pool_data !== 32'h0) begin bad++; $display("FAIL rstmid pool_data got %h want 0", pool_data); end
    total++; if (pool_ovr !== 1'b0) begin bad++; $display("FAIL rstmid pool_ovr got %b want 0", pool_ovr); end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (oq.size() !== 0 || ovc.size() !== 0) begin bad++; $display("FAIL rstmid leak got %0d/%0d want 0/0", oq.size(), ovc.size()); end
    clr();
    load(2, 2, 1'b0);
    fr = '{ftab[3], ftab[2], ftab[1], ftab[0]};
    send_frame(2, 2, 0);
    repeat (4) @(negedge clk);
    total++; if (oq.size() !== 1) begin bad++; $display("FAIL rstmid count got %0d want 1", oq.size()); end
    total++; if (oq.size() > 0 && oq[0] !== 32'h40800000) begin bad++; $display("FAIL rstmid data got %h want 40800000", oq[0]); end
    total++; if (ovc.size() !== 1 || ovc[0] !== exp_o[0] + 2) begin bad++; $display("FAIL rstmid ovr n=%0d got %0d want %0d", ovc.size(), ovc[0], exp_o[0] + 2); end
  endtask

  task automatic test_back_to_back;
    clr();
    load(8, 2, 1'b0);
    fr.delete(); for (int i = 0; i < 16; i++) fr.push_back(ftab[i]);
    send_frame(8, 2, 0);
    fr.delete(); for (int i = 15; i >= 0; i--) fr.push_back(ftab[i]);
    send_frame(8, 2, 0);
    exp_d = '{32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000,
              32'h41800000, 32'h41600000, 32'h41400000, 32'h41200000};
    load(32, 2, 1'b0);
    fr.delete();
    for (int c = 0; c < 32; c++) fr.push_back(ftab[c >> 1]);
    for (int c = 0; c < 32; c++) fr.push_back(32'hBF800000);
    for (int i = 0; i < 16; i++) exp_d.push_back(ftab[i]);
    send_frame(32, 2, 0);
    repeat (4) @(negedge clk);
    total++; if (oq.size() !== 24) begin bad++; $display("FAIL b2b count got %0d want 24", oq.size()); end
    foreach (exp_d[i]) if (i < oq.size()) begin
      total++; if (oq[i] !== exp_d[i]) begin bad++; $display("FAIL b2b data[%0d] got %h want %h", i, oq[i], exp_d[i]); end
      total++; if (oc[i] !== exp_c[i] + 2) begin bad++; $display("FAIL b2b latency[%0d] got %0d want %0d", i, oc[i], exp_c[i] + 2); end
    end
    total++; if (ovc.size() !== 3) begin bad++; $display("FAIL b2b ovr count got %0d want 3", ovc.size()); end
    foreach (exp_o[i]) if (i < ovc.size()) begin
      total++; if (ovc[i] !== exp_o[i] + 2) begin bad++; $display("FAIL b2b ovr[%0d] got %0d want %0d", i, ovc[i], exp_o[i] + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_4x4();
    test_negatives();
    test_odd_dims();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
